// File: rtl/ethernet_frame_header_parser.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_frame_header_parser
// Purpose  : Receive front end of the 10G reply path. Captures the 42-byte
//            Ethernet + IPv4/ARP header and the next 6 payload bytes from a
//            64-bit AXI-Stream and classifies the frame as ARP request,
//            ICMP echo request or UDP to the local port. Payload beats
//            6..N of accepted ICMP/UDP frames are forwarded with a fixed
//            latency of one clock.
// Ports    : i_clk, i_reset (async, active-high)
//            rx_axis_*                   input stream (no back-pressure)
//            data_head_reply             header bytes 0..41, byte 0 at MSB
//            data_head_frame_payload     frame bytes 42..47, byte 42 at MSB
//            data_head_frame_payload_keep  keep of bytes 42..47, bit5 = 42
//            data_head_valid/head_last   accept pulse / frame ended in beat 5
//            arp_valid/icmp_valid/udp_valid  one-hot class, held to next accept
//            pl_axis_*                   forwarded payload beats
//            frame_drop_cnt              saturating dropped-frame counter
// Revision : 1.0 - initial release
// ============================================================================
module ethernet_frame_header_parser #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164,
  parameter logic [15:0] UDP_PORT  = 16'd5000
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         rx_axis_tvalid,
  input  logic [63:0]  rx_axis_tdata,
  input  logic         rx_axis_tlast,
  input  logic [7:0]   rx_axis_tkeep,
  output logic [335:0] data_head_reply,
  output logic [47:0]  data_head_frame_payload,
  output logic [5:0]   data_head_frame_payload_keep,
  output logic         data_head_valid,
  output logic         head_last,
  output logic         arp_valid,
  output logic         icmp_valid,
  output logic         udp_valid,
  output logic         pl_axis_tvalid,
  output logic [63:0]  pl_axis_tdata,
  output logic         pl_axis_tlast,
  output logic [7:0]   pl_axis_tkeep,
  output logic [15:0]  frame_drop_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEAD     = 3'd1,
    CLASSIFY = 3'd2,
    PAYLOAD  = 3'd3,
    SKIP     = 3'd4,
    DROP     = 3'd5
  } state_t;

  state_t       r_state;
  logic [2:0]   r_beat_cnt;
  logic [383:0] r_hdr;      // 48 wire bytes, byte 0 ends up in [383:376]
  logic         r_last5;    // beat 5 carried tlast
  logic         r_accept;   // header decision taken on beat 5
  logic         r_fwd;      // accepted class forwards payload (ICMP/UDP)

  logic [63:0]  w_beat;     // incoming beat in wire order, lane 0 at MSB
  logic [383:0] w_hdr_next;
  logic [5:0]   w_keep6;
  logic [47:0]  w_pay;
  logic         w_mac_ok;
  logic         w_is_arp;
  logic         w_is_ipv4;
  logic         w_is_icmp;
  logic         w_is_udp;
  logic         w_accept;
  logic [15:0]  w_drop_inc;

  // Field extraction is done on the shift register contents as they will
  // be after the current beat, so the decision is ready on the beat-5 edge.
  function automatic logic [7:0] hbyte(input logic [383:0] h, input int n);
    return h[383-8*n -: 8];
  endfunction

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < 8; i++) begin
      w_beat[63-8*i -: 8] = rx_axis_tdata[8*i +: 8];
    end
  end

  assign w_hdr_next = {r_hdr[319:0], w_beat};

  assign w_mac_ok  = (w_hdr_next[383 -: 48] == LOCAL_MAC) ||
                     (w_hdr_next[383 -: 48] == 48'hFFFF_FFFF_FFFF);
  assign w_is_arp  = ({hbyte(w_hdr_next, 12), hbyte(w_hdr_next, 13)} == 16'h0806) &&
                     ({hbyte(w_hdr_next, 20), hbyte(w_hdr_next, 21)} == 16'h0001) &&
                     ({hbyte(w_hdr_next, 38), hbyte(w_hdr_next, 39),
                       hbyte(w_hdr_next, 40), hbyte(w_hdr_next, 41)} == LOCAL_IP);
  assign w_is_ipv4 = ({hbyte(w_hdr_next, 12), hbyte(w_hdr_next, 13)} == 16'h0800) &&
                     (hbyte(w_hdr_next, 14) == 8'h45) &&
                     ({hbyte(w_hdr_next, 30), hbyte(w_hdr_next, 31),
                       hbyte(w_hdr_next, 32), hbyte(w_hdr_next, 33)} == LOCAL_IP);
  assign w_is_icmp = w_is_ipv4 && (hbyte(w_hdr_next, 23) == 8'd1) &&
                     (hbyte(w_hdr_next, 34) == 8'd8);
  assign w_is_udp  = w_is_ipv4 && (hbyte(w_hdr_next, 23) == 8'd17) &&
                     ({hbyte(w_hdr_next, 36), hbyte(w_hdr_next, 37)} == UDP_PORT);
  assign w_accept  = w_mac_ok && (w_is_arp || w_is_icmp || w_is_udp);

  // A frame ending in beat 5 may not fill bytes 42..47; lane 2 is byte 42.
  assign w_keep6 = rx_axis_tlast ? {rx_axis_tkeep[2], rx_axis_tkeep[3], rx_axis_tkeep[4],
                                    rx_axis_tkeep[5], rx_axis_tkeep[6], rx_axis_tkeep[7]}
                                 : 6'h3F;

  always_comb begin
    w_pay = '0;
    for (int i = 0; i < 6; i++) begin
      if (w_keep6[5-i]) begin
        w_pay[47-8*i -: 8] = w_hdr_next[47-8*i -: 8];
      end
    end
  end

  assign w_drop_inc = (frame_drop_cnt == 16'hFFFF) ? frame_drop_cnt : frame_drop_cnt + 16'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state                      <= IDLE;
      r_beat_cnt                   <= 3'd0;
      r_hdr                        <= '0;
      r_last5                      <= 1'b0;
      r_accept                     <= 1'b0;
      r_fwd                        <= 1'b0;
      data_head_reply              <= '0;
      data_head_frame_payload      <= '0;
      data_head_frame_payload_keep <= '0;
      data_head_valid              <= 1'b0;
      head_last                    <= 1'b0;
      arp_valid                    <= 1'b0;
      icmp_valid                   <= 1'b0;
      udp_valid                    <= 1'b0;
      pl_axis_tvalid               <= 1'b0;
      pl_axis_tdata                <= '0;
      pl_axis_tlast                <= 1'b0;
      pl_axis_tkeep                <= '0;
      frame_drop_cnt               <= '0;
    end else begin
      data_head_valid <= 1'b0;
      pl_axis_tvalid  <= 1'b0;
      pl_axis_tdata   <= '0;
      pl_axis_tlast   <= 1'b0;
      pl_axis_tkeep   <= '0;

      case (r_state)
        IDLE: begin
          if (rx_axis_tvalid) begin
            r_hdr <= w_hdr_next;
            if (rx_axis_tlast) begin
              frame_drop_cnt <= w_drop_inc;
            end else begin
              r_beat_cnt <= 3'd1;
              r_state    <= HEAD;
            end
          end
        end

        HEAD: begin
          if (rx_axis_tvalid) begin
            r_hdr <= w_hdr_next;
            if (r_beat_cnt == 3'd5) begin
              r_beat_cnt <= 3'd0;
              r_last5    <= rx_axis_tlast;
              r_accept   <= w_accept;
              r_fwd      <= w_is_icmp || w_is_udp;
              r_state    <= CLASSIFY;
              if (w_accept) begin
                data_head_valid              <= 1'b1;
                data_head_reply              <= w_hdr_next[383:48];
                data_head_frame_payload      <= w_pay;
                data_head_frame_payload_keep <= w_keep6;
                head_last                    <= rx_axis_tlast;
                arp_valid                    <= w_is_arp;
                icmp_valid                   <= w_is_icmp;
                udp_valid                    <= w_is_udp;
              end else begin
                frame_drop_cnt <= w_drop_inc;
              end
            end else if (rx_axis_tlast) begin
              r_beat_cnt     <= 3'd0;
              frame_drop_cnt <= w_drop_inc;
              r_state        <= IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 3'd1;
            end
          end
        end

        // Any beat arriving here belongs either to the next frame (beat 5
        // was last) or to this frame's payload, and is handled accordingly.
        CLASSIFY: begin
          if (r_last5) begin
            r_state <= IDLE;
            if (rx_axis_tvalid) begin
              r_hdr <= w_hdr_next;
              if (rx_axis_tlast) begin
                frame_drop_cnt <= w_drop_inc;
              end else begin
                r_beat_cnt <= 3'd1;
                r_state    <= HEAD;
              end
            end
          end else if (r_accept && r_fwd) begin
            r_state <= PAYLOAD;
            if (rx_axis_tvalid) begin
              pl_axis_tvalid <= 1'b1;
              pl_axis_tdata  <= rx_axis_tdata;
              pl_axis_tlast  <= rx_axis_tlast;
              pl_axis_tkeep  <= rx_axis_tkeep;
              if (rx_axis_tlast) begin
                r_state <= IDLE;
              end
            end
          end else begin
            r_state <= r_accept ? SKIP : DROP;
            if (rx_axis_tvalid && rx_axis_tlast) begin
              r_state <= IDLE;
            end
          end
        end

        PAYLOAD: begin
          if (rx_axis_tvalid) begin
            pl_axis_tvalid <= 1'b1;
            pl_axis_tdata  <= rx_axis_tdata;
            pl_axis_tlast  <= rx_axis_tlast;
            pl_axis_tkeep  <= rx_axis_tkeep;
            if (rx_axis_tlast) begin
              r_state <= IDLE;
            end
          end
        end

        SKIP, DROP: begin
          if (rx_axis_tvalid && rx_axis_tlast) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ethernet_frame_header_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethernet_frame_header_parser
// Purpose  : Directed self-checking bench. Frames are built byte-by-byte,
//            expected header events and payload beats (with the clock cycle
//            they must appear in) are queued while driving, and a negedge
//            monitor pops and compares them against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ethernet_frame_header_parser;

  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BMAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] LIP  = 32'hC0A8_0164;
  localparam int K_ICMP = 0;
  localparam int K_UDP  = 1;
  localparam int K_ARP  = 2;
  localparam logic [2:0] C_ARP  = 3'b100;
  localparam logic [2:0] C_ICMP = 3'b010;
  localparam logic [2:0] C_UDP  = 3'b001;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         rx_axis_tvalid = 1'b0;
  logic [63:0]  rx_axis_tdata = '0;
  logic         rx_axis_tlast = 1'b0;
  logic [7:0]   rx_axis_tkeep = '0;
  logic [335:0] data_head_reply;
  logic [47:0]  data_head_frame_payload;
  logic [5:0]   data_head_frame_payload_keep;
  logic         data_head_valid;
  logic         head_last;
  logic         arp_valid;
  logic         icmp_valid;
  logic         udp_valid;
  logic         pl_axis_tvalid;
  logic [63:0]  pl_axis_tdata;
  logic         pl_axis_tlast;
  logic [7:0]   pl_axis_tkeep;
  logic [15:0]  frame_drop_cnt;

  ethernet_frame_header_parser dut (
    .i_clk                        (i_clk),
    .i_reset                      (i_reset),
    .rx_axis_tvalid               (rx_axis_tvalid),
    .rx_axis_tdata                (rx_axis_tdata),
    .rx_axis_tlast                (rx_axis_tlast),
    .rx_axis_tkeep                (rx_axis_tkeep),
    .data_head_reply              (data_head_reply),
    .data_head_frame_payload      (data_head_frame_payload),
    .data_head_frame_payload_keep (data_head_frame_payload_keep),
    .data_head_valid              (data_head_valid),
    .head_last                    (head_last),
    .arp_valid                    (arp_valid),
    .icmp_valid                   (icmp_valid),
    .udp_valid                    (udp_valid),
    .pl_axis_tvalid               (pl_axis_tvalid),
    .pl_axis_tdata                (pl_axis_tdata),
    .pl_axis_tlast                (pl_axis_tlast),
    .pl_axis_tkeep                (pl_axis_tkeep),
    .frame_drop_cnt               (frame_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [2:0]   cls;
    logic         last;
    logic [5:0]   keep;
    logic [335:0] reply;
    logic [47:0]  pay;
  } hd_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
  } pl_t;

  hd_t        hq[$];
  pl_t        pq[$];
  logic [7:0] fr[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_drop = 0;
  logic [2:0] last_cls = 3'b000;

  task automatic check(input string tag, input logic [335:0] obs, input logic [335:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- frame construction ----------------
  task automatic push_n(input logic [47:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) fr.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input int kind, input logic [47:0] dmac, input logic [31:0] dip,
                       input logic [15:0] dport, input int len);
    fr.delete();
    push_n(dmac, 6);
    push_n(48'h02_00_00_00_00_AA, 6);
    if (kind == K_ARP) begin
      push_n(48'h0806, 2); push_n(48'h0001, 2); push_n(48'h0800, 2);
      push_n(48'h06, 1);   push_n(48'h04, 1);   push_n(48'h0001, 2);
      push_n(48'h02_00_00_00_00_AA, 6); push_n(48'hC0A8_0101, 4);
      push_n(48'h0, 6);    push_n({16'h0, dip}, 4);
    end else begin
      push_n(48'h0800, 2); push_n(48'h45, 1); push_n(48'h00, 1);
      push_n(48'(len - 14), 2); push_n(48'h1234, 2); push_n(48'h4000, 2);
      push_n(48'h40, 1); push_n((kind == K_ICMP) ? 48'd1 : 48'd17, 1);
      push_n(48'h0, 2); push_n(48'hC0A8_0101, 4); push_n({16'h0, dip}, 4);
      if (kind == K_ICMP) begin
        push_n(48'h08, 1); push_n(48'h00, 1); push_n(48'h0, 2);
        push_n(48'h0001, 2); push_n(48'h0007, 2);
      end else begin
        push_n(48'd40000, 2); push_n({32'h0, dport}, 2);
        push_n(48'(len - 34), 2); push_n(48'h0, 2);
      end
    end
    while (fr.size() < len) fr.push_back(8'(fr.size() * 7 + 3));
    while (fr.size() > len) void'(fr.pop_back());
  endtask

  // ---------------- driving ----------------
  task automatic idle();
    @(posedge i_clk); #1;
    rx_axis_tvalid = 1'b0; rx_axis_tdata = '0; rx_axis_tlast = 1'b0; rx_axis_tkeep = '0;
  endtask

  // Unused lanes carry 8'hEE so zero-forcing of missing bytes is visible.
  task automatic drive_beat(input int k, input int nb);
    int idx;
    @(posedge i_clk); #1;
    for (int l = 0; l < 8; l++) begin
      idx = 8 * k + l;
      if (idx < fr.size()) begin
        rx_axis_tdata[8*l +: 8] = fr[idx]; rx_axis_tkeep[l] = 1'b1;
      end else begin
        rx_axis_tdata[8*l +: 8] = 8'hEE;   rx_axis_tkeep[l] = 1'b0;
      end
    end
    rx_axis_tvalid = 1'b1;
    rx_axis_tlast  = (k == nb - 1);
  endtask

  task automatic push_head(input logic [2:0] cls, input int nb);
    hd_t e;
    e.cyc  = cyc + 1;
    e.cls  = cls;
    e.last = (nb == 6);
    e.reply = '0;
    e.pay   = '0;
    e.keep  = '0;
    for (int i = 0; i < 42; i++) e.reply[335-8*i -: 8] = fr[i];
    for (int i = 0; i < 6; i++) begin
      if (42 + i < fr.size()) begin
        e.keep[5-i] = 1'b1;
        e.pay[47-8*i -: 8] = fr[42+i];
      end
    end
    hq.push_back(e);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic send_frame(input string name, input bit acc, input logic [2:0] cls,
                            input bit fwd, input bit gaps);
    int nb;
    pl_t p;
    nb = (fr.size() + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      drive_beat(k, nb);
      if (k == 5 && acc) push_head(cls, nb);
      if (k >= 6 && acc && fwd) begin
        p.cyc = cyc + 1; p.data = rx_axis_tdata; p.last = rx_axis_tlast; p.keep = rx_axis_tkeep;
        pq.push_back(p);
      end
      if (gaps && k != nb - 1) idle();
    end
    idle();
    if (acc) last_cls = cls;
    else if (exp_drop < 16'hFFFF) exp_drop++;
    settle(4);
    check({name, "_drop_cnt"},  336'(frame_drop_cnt), 336'(exp_drop));
    check({name, "_head_pend"}, 336'(hq.size()), 336'(0));
    check({name, "_pl_pend"},   336'(pq.size()), 336'(0));
    check({name, "_class_hold"}, 336'({arp_valid, icmp_valid, udp_valid}), 336'(last_cls));
  endtask

  task automatic check_zero(input string name);
    check({name, "_reply"}, data_head_reply, 336'(0));
    check({name, "_pay"}, 336'({data_head_frame_payload, data_head_frame_payload_keep}), 336'(0));
    check({name, "_flags"}, 336'({data_head_valid, head_last, arp_valid, icmp_valid, udp_valid}), 336'(0));
    check({name, "_pl"}, 336'({pl_axis_tvalid, pl_axis_tdata, pl_axis_tlast, pl_axis_tkeep}), 336'(0));
    check({name, "_drop"}, 336'(frame_drop_cnt), 336'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (data_head_valid) begin
        if (hq.size() == 0) begin
          check("head_unexpected", 336'(1), 336'(0));
        end else begin
          hd_t e;
          e = hq.pop_front();
          check("head_cycle", 336'(cyc), 336'(e.cyc));
          check("head_class", 336'({arp_valid, icmp_valid, udp_valid}), 336'(e.cls));
          check("head_last", 336'(head_last), 336'(e.last));
          check("head_keep", 336'(data_head_frame_payload_keep), 336'(e.keep));
          check("head_reply", data_head_reply, e.reply);
          check("head_payload", 336'(data_head_frame_payload), 336'(e.pay));
        end
      end
      if (pl_axis_tvalid) begin
        if (pq.size() == 0) begin
          check("pl_unexpected", 336'(1), 336'(0));
        end else begin
          pl_t p;
          p = pq.pop_front();
          check("pl_cycle", 336'(cyc), 336'(p.cyc));
          check("pl_beat", 336'({pl_axis_tdata, pl_axis_tlast, pl_axis_tkeep}),
                336'({p.data, p.last, p.keep}));
        end
      end else begin
        check("pl_idle_zero", 336'({pl_axis_tdata, pl_axis_tlast, pl_axis_tkeep}), 336'(0));
      end
    end
  end

  initial begin
    repeat (20000) @(posedge i_clk);
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check_zero("reset_held");
    i_reset = 1'b0;
    settle(2);
    check_zero("after_reset");

    build(K_ICMP, LMAC, LIP, 16'd0, 98);
    send_frame("icmp98", 1'b1, C_ICMP, 1'b1, 1'b0);

    build(K_ARP, BMAC, LIP, 16'd0, 42);
    send_frame("arp42", 1'b1, C_ARP, 1'b0, 1'b0);

    build(K_ARP, BMAC, LIP, 16'd0, 60);
    send_frame("arp60", 1'b1, C_ARP, 1'b0, 1'b0);

    build(K_UDP, LMAC, LIP, 16'd5001, 80);
    send_frame("udp5001", 1'b0, 3'b000, 1'b0, 1'b0);

    build(K_UDP, LMAC, LIP, 16'd5000, 80);
    send_frame("udp5000", 1'b1, C_UDP, 1'b1, 1'b0);

    build(K_ICMP, LMAC, LIP, 16'd0, 60);
    while (fr.size() > 24) void'(fr.pop_back());
    send_frame("runt", 1'b0, 3'b000, 1'b0, 1'b0);

    build(K_UDP, BMAC, LIP, 16'd5000, 45);
    send_frame("udp45_after_runt", 1'b1, C_UDP, 1'b1, 1'b0);

    build(K_ICMP, LMAC, LIP, 16'd0, 98);
    send_frame("icmp98_gaps", 1'b1, C_ICMP, 1'b1, 1'b1);

    build(K_ICMP, 48'h02_00_00_00_00_02, LIP, 16'd0, 64);
    send_frame("icmp_wrong_mac", 1'b0, 3'b000, 1'b0, 1'b0);

    build(K_ICMP, LMAC, 32'hC0A8_0165, 16'd0, 64);
    send_frame("icmp_wrong_ip", 1'b0, 3'b000, 1'b0, 1'b0);

    // Reset asserted while beat 3 of a UDP frame is on the bus.
    build(K_UDP, LMAC, LIP, 16'd5000, 80);
    for (int k = 0; k < 4; k++) drive_beat(k, 10);
    #2;
    i_reset = 1'b1;
    #1;
    check_zero("reset_midframe");
    exp_drop = 0;
    last_cls = 3'b000;
    idle();
    idle();
    i_reset = 1'b0;
    settle(1);

    build(K_UDP, LMAC, LIP, 16'd5000, 72);
    send_frame("udp_after_reset", 1'b1, C_UDP, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
